// File: rtl/spi_master_shifter.sv
// SPI mode-0 master shifter: one DATA_W-bit full-duplex word per start, MSB first,
// with a CLK_DIV-cycle lead-in and trail-out around the SCLK burst.
module spi_master_shifter #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              SCLK,
  output logic              MOSI,
  input  logic              MISO,
  output logic              CS_N
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

  state_t state, state_nxt;

  logic [DIV_W-1:0]  div_cnt, div_cnt_nxt;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [DATA_W-1:0] tx_sr, tx_sr_nxt;
  logic [DATA_W-1:0] rx_sr, rx_sr_nxt;
  logic [DATA_W-1:0] rx_data_nxt;
  logic              sclk_nxt, mosi_nxt, cs_n_nxt, busy_nxt, done_nxt;
  logic              phase_end, last_bit, miso_bit;

  assign phase_end = (div_cnt == DIV_LAST);
  assign last_bit  = (bit_cnt == BIT_LAST);
  // Floating or unknown MISO is taken as 0 rather than propagated.
  assign miso_bit  = (MISO === 1'b1);

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = LEAD;
      LEAD:    if (phase_end) state_nxt = XFER;
      XFER:    if (phase_end && SCLK && last_bit) state_nxt = TRAIL;
      TRAIL:   if (phase_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Every output is produced here as a next value and registered below; the SCLK
  // register doubles as the half-period phase flag during XFER.
  always_comb begin
    div_cnt_nxt = phase_end ? '0 : div_cnt + DIV_W'(1);
    bit_cnt_nxt = bit_cnt;
    tx_sr_nxt   = tx_sr;
    rx_sr_nxt   = rx_sr;
    rx_data_nxt = rx_data;
    sclk_nxt    = 1'b0;
    mosi_nxt    = MOSI;
    cs_n_nxt    = CS_N;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    unique case (state)
      IDLE: begin
        div_cnt_nxt = '0;
        mosi_nxt    = 1'b0;
        if (start) begin
          tx_sr_nxt   = tx_data;
          bit_cnt_nxt = '0;
          mosi_nxt    = tx_data[DATA_W-1];
          cs_n_nxt    = 1'b0;
          busy_nxt    = 1'b1;
        end
      end
      LEAD: ;
      XFER: begin
        sclk_nxt = SCLK;
        if (phase_end) begin
          if (!SCLK) begin
            sclk_nxt  = 1'b1;
            rx_sr_nxt = {rx_sr[DATA_W-2:0], miso_bit};
          end else begin
            sclk_nxt = 1'b0;
            if (!last_bit) begin
              bit_cnt_nxt = bit_cnt + BIT_W'(1);
              tx_sr_nxt   = {tx_sr[DATA_W-2:0], 1'b0};
              mosi_nxt    = tx_sr[DATA_W-2];
            end
          end
        end
      end
      TRAIL: begin
        if (phase_end) begin
          cs_n_nxt    = 1'b1;
          busy_nxt    = 1'b0;
          done_nxt    = 1'b1;
          mosi_nxt    = 1'b0;
          rx_data_nxt = rx_sr;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      rx_data <= '0;
      SCLK    <= 1'b0;
      MOSI    <= 1'b0;
      CS_N    <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      div_cnt <= div_cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
      tx_sr   <= tx_sr_nxt;
      rx_sr   <= rx_sr_nxt;
      rx_data <= rx_data_nxt;
      SCLK    <= sclk_nxt;
      MOSI    <= mosi_nxt;
      CS_N    <= cs_n_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_spi_master_shifter.sv
// Bench for spi_master_shifter: an 8-bit/div-2 and a 16-bit/div-1 instance, each
// served by a MISO responder, with expected words queued and checked on done.
module tb_spi_master_shifter;

  typedef struct {
    int          inst;
    logic [31:0] rx;
    int          done_cyc;
  } exp_t;

  logic        CLK = 1'b0;
  logic        CLR = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [7:0]  tx0 = '0;
  logic [15:0] tx1 = '0;
  logic        miso0 = 1'b0, miso1 = 1'b0;
  logic        busy0, done0, sclk0, mosi0, csn0;
  logic        busy1, done1, sclk1, mosi1, csn1;
  logic [7:0]  rx8;
  logic [15:0] rx16;

  int          cyc = 0;
  int          tests_run = 0;
  int          tests_failed = 0;
  exp_t        sbq[$];
  // MISO responder per instance: 0 loopback, 1 constant one, 2 floating, 3 slave word
  int          mode[2];
  logic [31:0] slave_w[2];
  int          rise_cnt[2];
  int          low_cnt[2];
  int          mosi_hi_total[2];
  logic        prev_sclk[2];

  spi_master_shifter #(.DATA_W(8), .CLK_DIV(2)) u_dut8 (
    .CLK(CLK), .CLR(CLR), .start(start0), .tx_data(tx0), .busy(busy0), .done(done0),
    .rx_data(rx8), .SCLK(sclk0), .MOSI(mosi0), .MISO(miso0), .CS_N(csn0)
  );

  spi_master_shifter #(.DATA_W(16), .CLK_DIV(1)) u_dut16 (
    .CLK(CLK), .CLR(CLR), .start(start1), .tx_data(tx1), .busy(busy1), .done(done1),
    .rx_data(rx16), .SCLK(sclk1), .MOSI(mosi1), .MISO(miso1), .CS_N(csn1)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic int widthOf(input int inst);
    return (inst == 0) ? 8 : 16;
  endfunction

  function automatic int latOf(input int inst);
    return (inst == 0) ? 2 * (2 * 8 + 2) : 1 * (2 * 16 + 2);
  endfunction

  // What the master must end up holding, given what the responder put on MISO.
  function automatic logic [31:0] refRx(input int inst, input logic [31:0] w,
                                        input int m, input logic [31:0] sw);
    logic [31:0] mask;
    mask = (inst == 0) ? 32'h0000_00FF : 32'h0000_FFFF;
    case (m)
      0:       return w & mask;
      1:       return mask;
      2:       return 32'h0;
      default: return sw & mask;
    endcase
  endfunction

  function automatic logic misoFor(input int inst, input logic mosi);
    int w;
    w = widthOf(inst);
    case (mode[inst])
      0: return mosi;
      1: return 1'b1;
      2: return 1'bz;
      default: begin
        if (rise_cnt[inst] < w) return slave_w[inst][w - 1 - rise_cnt[inst]];
        return 1'b0;
      end
    endcase
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic checkOutput(input int inst, input logic dn, input logic [31:0] rx,
                             input logic csn, input logic bsy);
    exp_t e;
    if (dn === 1'b1) begin
      if (sbq.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_done: inst %0d got done with rx 0x%0h, required no done", inst, rx);
      end else begin
        e = sbq.pop_front();
        cmp("done_inst", inst, e.inst);
        cmp("rx_data", rx, e.rx);
        cmp("done_cycle", cyc, e.done_cyc);
        cmp("sclk_rises", rise_cnt[inst], widthOf(inst));
        cmp("cs_low_cycles", low_cnt[inst], latOf(inst));
        cmp("done_cs_n", {31'b0, csn}, 32'd1);
        cmp("done_busy", {31'b0, bsy}, 32'd0);
      end
    end
  endtask

  task automatic trackSerial(input int inst, input logic sclk, input logic csn, input logic mosi);
    if (mosi === 1'b1) mosi_hi_total[inst]++;
    if (csn !== 1'b0) begin
      rise_cnt[inst] = 0;
      low_cnt[inst]  = 0;
    end else begin
      low_cnt[inst]++;
      if (sclk === 1'b1 && prev_sclk[inst] !== 1'b1) rise_cnt[inst]++;
    end
    prev_sclk[inst] = sclk;
  endtask

  always @(negedge CLK) begin
    checkOutput(0, done0, {24'b0, rx8}, csn0, busy0);
    checkOutput(1, done1, {16'b0, rx16}, csn1, busy1);
    trackSerial(0, sclk0, csn0, mosi0);
    trackSerial(1, sclk1, csn1, mosi1);
    miso0 = misoFor(0, mosi0);
    miso1 = misoFor(1, mosi1);
  end

  task automatic expectDone(input int inst, input logic [31:0] w, input int m, input logic [31:0] sw);
    exp_t e;
    e.inst     = inst;
    e.rx       = refRx(inst, w, m, sw);
    e.done_cyc = cyc + latOf(inst);
    sbq.push_back(e);
  endtask

  // Returns at the negedge following the accepting edge, so cyc is that edge's number.
  task automatic applyStimulus(input int inst, input logic [31:0] w, input int m,
                               input logic [31:0] sw, input bit expect_done);
    @(negedge CLK);
    mode[inst]    = m;
    slave_w[inst] = sw;
    if (inst == 0) begin tx0 = w[7:0];  start0 = 1'b1; end
    else           begin tx1 = w[15:0]; start1 = 1'b1; end
    @(negedge CLK);
    start0 = 1'b0;
    start1 = 1'b0;
    if (expect_done) expectDone(inst, w, m, sw);
  endtask

  task automatic waitDone(input int budget);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    cmp("done_timeout_pending", sbq.size(), 0);
    sbq.delete();
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc;
    int snap;
    int pick;
    int m;
    int inst;
    for (int i = 0; i < 2; i++) begin
      mode[i] = 0; slave_w[i] = '0; rise_cnt[i] = 0; low_cnt[i] = 0;
      mosi_hi_total[i] = 0; prev_sclk[i] = 1'b0;
    end

    // Reset values of both instances
    #2 CLR = 1'b1;
    repeat (3) @(negedge CLK);
    cmp("rst_cs_n0", {31'b0, csn0}, 32'd1);
    cmp("rst_sclk0", {31'b0, sclk0}, 32'd0);
    cmp("rst_mosi0", {31'b0, mosi0}, 32'd0);
    cmp("rst_busy0", {31'b0, busy0}, 32'd0);
    cmp("rst_done0", {31'b0, done0}, 32'd0);
    cmp("rst_rx0", {24'b0, rx8}, 32'd0);
    cmp("rst_cs_n1", {31'b0, csn1}, 32'd1);
    cmp("rst_busy1", {31'b0, busy1}, 32'd0);
    cmp("rst_rx1", {16'b0, rx16}, 32'd0);
    CLR = 1'b0;
    repeat (2) @(negedge CLK);

    // Loopback of 0xA5
    applyStimulus(0, 32'hA5, 0, 0, 1);
    cmp("accept_busy", {31'b0, busy0}, 32'd1);
    cmp("accept_mosi_msb", {31'b0, mosi0}, 32'd1);
    waitDone(100);

    // MISO stuck high with zero word, then floating MISO
    snap = mosi_hi_total[0];
    applyStimulus(0, 32'h00, 1, 0, 1);
    waitDone(100);
    cmp("mosi_zero_count", mosi_hi_total[0] - snap, 0);
    applyStimulus(0, 32'hC3, 2, 0, 1);
    waitDone(100);

    // A second start mid-transfer with a new word must be ignored
    applyStimulus(0, 32'h96, 0, 0, 1);
    acc = cyc;
    waitUntil(acc + 10);
    tx0 = 8'h3C;
    start0 = 1'b1;
    @(negedge CLK);
    start0 = 1'b0;
    waitDone(100);
    repeat (50) @(negedge CLK);

    // Asynchronous abort during bit 3, then a clean transfer
    applyStimulus(0, 32'h77, 0, 0, 0);
    acc = cyc;
    waitUntil(acc + 15);
    #2 CLR = 1'b1;
    #1;
    cmp("abort_cs_n", {31'b0, csn0}, 32'd1);
    cmp("abort_sclk", {31'b0, sclk0}, 32'd0);
    cmp("abort_busy", {31'b0, busy0}, 32'd0);
    cmp("abort_mosi", {31'b0, mosi0}, 32'd0);
    cmp("abort_rx", {24'b0, rx8}, 32'd0);
    repeat (2) @(negedge CLK);
    CLR = 1'b0;
    repeat (60) @(negedge CLK);
    applyStimulus(0, 32'h5A, 0, 0, 1);
    waitDone(100);

    // Start held during the done cycle gives a back-to-back transfer
    applyStimulus(0, 32'h24, 0, 0, 1);
    acc = cyc;
    waitUntil(acc + latOf(0));
    tx0 = 8'h81;
    start0 = 1'b1;
    @(negedge CLK);
    start0 = 1'b0;
    expectDone(0, 32'h81, 0, 0);
    cmp("b2b_cs_n", {31'b0, csn0}, 32'd0);
    waitDone(100);

    // 16-bit word at the fastest divider
    applyStimulus(1, 32'hBEEF, 0, 0, 1);
    waitDone(100);

    // Randomised words and responder behaviour on both instances
    for (int i = 0; i < 16; i++) begin
      inst = i % 2;
      pick = $urandom_range(0, 2);
      m = (pick == 2) ? 3 : pick;
      applyStimulus(inst, $urandom, m, $urandom, 1);
      waitDone(100);
      repeat ($urandom_range(0, 3)) @(negedge CLK);
    end

    repeat (5) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/spi_master_shifter.md
SPI_MASTER_SHIFTER -- requirements
Module: spi_master_shifter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the word length in bits (range 2..32).
REQ-002 The block SHALL have parameter CLK_DIV, default 2, giving the SCLK half-period in CLK cycles (at least 1).
REQ-003 The block SHALL have port CLK, input, 1 bit: system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port CLR, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port start, input, 1 bit: request a transfer of tx_data.
REQ-006 The block SHALL have port tx_data, input, DATA_W bits: word to transmit, MSB first.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a transfer is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse at transfer completion.
REQ-009 The block SHALL have port rx_data, output, DATA_W bits: last received word.
REQ-010 The block SHALL have port SCLK, output, 1 bit: serial clock, SPI mode 0 with idle level low.
REQ-011 The block SHALL have port MOSI, output, 1 bit: serial data out.
REQ-012 The block SHALL have port MISO, input, 1 bit: serial data in.
REQ-013 The block SHALL have port CS_N, output, 1 bit: chip select, active-low.

Function
REQ-014 The FSM SHALL have states IDLE, LEAD, XFER and TRAIL; every output SHALL be registered.
REQ-015 In IDLE, start=1 sampled at a CLK edge SHALL:
- latch tx_data into the TX shift register;
- enter LEAD;
- at that same edge, set CS_N=0, busy=1 and MOSI=tx_data[DATA_W-1].
REQ-016 The block SHALL ignore start outside IDLE; tx_data changes after acceptance SHALL have no effect.
REQ-017 LEAD SHALL last CLK_DIV cycles with SCLK=0, then enter XFER.
REQ-018 In XFER, each bit SHALL take 2*CLK_DIV cycles: CLK_DIV cycles with SCLK=0, then CLK_DIV cycles with SCLK=1.
REQ-019 At the CLK edge that drives SCLK from 0 to 1, the block SHALL shift MISO into the RX shift register LSB.
REQ-020 MISO values of z or x SHALL be captured as 0.
REQ-021 At the CLK edge that drives SCLK from 1 to 0, MOSI SHALL advance to the next TX bit, except after the last bit.
REQ-022 A bit counter SHALL count 0..DATA_W-1; after the high phase of bit DATA_W-1 the FSM SHALL enter TRAIL with SCLK=0.
REQ-023 TRAIL SHALL last CLK_DIV cycles, then return to IDLE. At that same edge:
- CS_N=1, busy=0, done=1 for exactly one cycle;
- rx_data updates to the RX shift register.
REQ-024 rx_data SHALL hold its value until the next done.
REQ-025 Latency from the start-accepting edge to the done edge SHALL be CLK_DIV*(2*DATA_W+2) cycles; with default parameters this is 36 cycles.
REQ-026 start=1 during the done cycle SHALL be accepted, giving back-to-back transfers with one CS_N-high cycle between them.
REQ-027 In IDLE, MOSI SHALL be 0 and SCLK SHALL be 0.

Reset
REQ-028 CLR=1 SHALL immediately, without waiting for CLK, force the following, and CLR SHALL override start:
- state=IDLE;
- CS_N=1, SCLK=0, MOSI=0, busy=0, done=0, rx_data=0;
- both shift registers and the bit counter to 0.
REQ-029 CLR asserted mid-transfer SHALL abort without a done pulse; the first start after CLR deasserts SHALL behave as a normal transfer.

Verification
REQ-030 The bench SHALL drive tx_data=0xA5 with MISO looped from MOSI, start for 1 cycle -> 8 SCLK rising edges, done at cycle 36, rx_data=0xA5, CS_N low for cycles 0..35.
REQ-031 The bench SHALL tie MISO=1, tx_data=0x00 -> rx_data=0xFF and MOSI=0 throughout; then MISO=z -> rx_data=0x00.
REQ-032 The bench SHALL pulse start again at cycle 10 of a transfer with tx_data=0x3C -> ignored: first word completes unchanged, exactly one done.
REQ-033 The bench SHALL assert CLR asynchronously between CLK edges during bit 3 -> CS_N=1, SCLK=0, busy=0 at once, no done; next transfer of 0x5A loopback returns 0x5A.
REQ-034 The bench SHALL hold start high during the done cycle with tx_data=0x81 -> second transfer starts next edge, rx_data=0x81 at its done, 36 cycles later.
REQ-035 The bench SHALL run CLK_DIV=1, DATA_W=16, tx_data=0xBEEF loopback -> done at cycle 34, rx_data=0xBEEF.
